// File: rtl/way_replace_ctrl.sv
// Hit-way encoder and victim selector for an 8-way set-associative L2, with
// per-set tree pseudo-LRU state and a valid/ready request/response handshake.
module way_replace_ctrl #(
  parameter int SET_BITS = 4,
  parameter int WAYS     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [WAYS-1:0]     req_hit,
  input  logic [WAYS-1:0]     req_valid_ways,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2:0]          resp_way,
  output logic                resp_hit,
  output logic                resp_err
);

  localparam int NUM_SETS = 2 ** SET_BITS;

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, RESP} state_t;

  state_t              state, state_next;
  logic [SET_BITS-1:0] set_q;
  logic [WAYS-1:0]     hit_q;
  logic [WAYS-1:0]     valid_q;
  logic [2:0]          way_q;
  logic                hit_r;
  logic                err_r;
  logic [6:0]          plru [NUM_SETS];

  logic [2:0]          eval_way;
  logic                eval_hit;
  logic                eval_err;
  logic [6:0]          cur_entry;

  function automatic logic [2:0] lowest_one(input logic [WAYS-1:0] v);
    lowest_one = 3'd0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_one = 3'(i);
    end
  endfunction

  // Walk the tree: each node bit names the half that holds the victim.
  function automatic logic [2:0] plru_victim(input logic [6:0] b);
    logic       v2, v1;
    logic [2:0] leaf;
    v2   = b[0];
    v1   = v2 ? b[2] : b[1];
    leaf = 3'd3 + {1'b0, v2, v1};
    plru_victim = {v2, v1, b[leaf]};
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
    logic [2:0] leaf;
    plru_touch                      = b;
    plru_touch[0]                   = ~w[2];
    plru_touch[w[2] ? 3'd2 : 3'd1]  = ~w[1];
    leaf                            = 3'd3 + {1'b0, w[2:1]};
    plru_touch[leaf]                = ~w[0];
  endfunction

  assign req_ready  = (state == IDLE) && !flush && !rst;
  assign resp_valid = (state == RESP);
  assign resp_way   = way_q;
  assign resp_hit   = hit_r;
  assign resp_err   = err_r;
  assign cur_entry  = plru[set_q];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave a value held (a latch).
  always_comb begin
    eval_way = 3'd0;
    eval_hit = 1'b0;
    eval_err = 1'b0;
    if (hit_q != '0) begin
      eval_way = lowest_one(hit_q);
      eval_hit = 1'b1;
      eval_err = |(hit_q & (hit_q - 1'b1));
    end else if (!(&valid_q)) begin
      eval_way = lowest_one(~valid_q);
    end else begin
      eval_way = plru_victim(cur_entry);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid && req_ready) state_next = EVAL;
      EVAL:    state_next = UPDATE;
      UPDATE:  state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      set_q   <= '0;
      hit_q   <= '0;
      valid_q <= '0;
      way_q   <= 3'd0;
      hit_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid && req_ready) begin
        set_q   <= req_set;
        hit_q   <= req_hit;
        valid_q <= req_valid_ways;
      end
      if (state == EVAL) begin
        way_q <= eval_way;
        hit_r <= eval_hit;
        err_r <= eval_err;
      end
    end
  end

  // NOTE: the PLRU array is small and must read as all-zero after reset or
  // flush, so it is cleared entry by entry here rather than left unreset.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && flush)) begin
      for (int s = 0; s < NUM_SETS; s++) plru[s] <= 7'b0;
    end else if (state == UPDATE) begin
      plru[set_q] <= plru_touch(cur_entry, way_q);
    end
  end

endmodule

// File: tb/tb_way_replace_ctrl.sv
// Directed bench for way_replace_ctrl: hit encoding, invalid-way allocation,
// PLRU victim sequence, response hold, reset mid-flight and flush.
module tb_way_replace_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_set;
  logic [7:0] req_hit;
  logic [7:0] req_valid_ways;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_way;
  logic       resp_hit;
  logic       resp_err;

  int checks = 0;
  int errors = 0;

  way_replace_ctrl #(.SET_BITS(4), .WAYS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_set        (req_set),
    .req_hit        (req_hit),
    .req_valid_ways (req_valid_ways),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_way       (resp_way),
    .resp_hit       (resp_hit),
    .resp_err       (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle; resp_ready must be 1.
  task automatic do_req(input logic [3:0] s, input logic [7:0] h, input logic [7:0] v,
                        input logic [2:0] ew, input logic eh, input logic ee,
                        input string tag);
    req_valid = 1'b1; req_set = s; req_hit = h; req_valid_ways = v;
    #1;
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_hit = 8'h00; req_valid_ways = 8'h00;
    check({tag, "_eval_busy"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_upd_busy"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_way"}, 32'(resp_way), 32'(ew));
    check({tag, "_hit"}, 32'(resp_hit), 32'(eh));
    check({tag, "_err"}, 32'(resp_err), 32'(ee));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_set = 4'd0;
    req_hit = 8'h00; req_valid_ways = 8'h00; resp_ready = 1'b1;

    // 1: reset state, then PLRU victim sequence on set 0
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_way", 32'(resp_way), 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    do_req(4'd0, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "plru0");
    do_req(4'd0, 8'h00, 8'hFF, 3'd4, 1'b0, 1'b0, "plru1");
    do_req(4'd0, 8'h00, 8'hFF, 3'd2, 1'b0, 1'b0, "plru2");
    do_req(4'd0, 8'h00, 8'hFF, 3'd6, 1'b0, 1'b0, "plru3");

    // 2: hit updates PLRU; other sets untouched
    do_req(4'd2, 8'h20, 8'hFF, 3'd5, 1'b1, 1'b0, "hit5");
    do_req(4'd2, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "s2_miss");
    do_req(4'd3, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "s3_miss");

    // 3: lowest invalid way, then PLRU after that allocation
    do_req(4'd1, 8'h00, 8'hF7, 3'd3, 1'b0, 1'b0, "inval3");
    do_req(4'd1, 8'h00, 8'hFF, 3'd4, 1'b0, 1'b0, "s1_plru");

    // 4: multi-hit error and top way hit
    do_req(4'd1, 8'h12, 8'hFF, 3'd1, 1'b1, 1'b1, "multihit");
    do_req(4'd1, 8'h80, 8'hFF, 3'd7, 1'b1, 1'b0, "hit7");

    // 5: response held under back-pressure, requests ignored
    resp_ready = 1'b0;
    req_valid = 1'b1; req_set = 4'd5; req_hit = 8'h08; req_valid_ways = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_way", 32'(resp_way), 32'd3);
      check("hold_hit", 32'(resp_hit), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      req_valid = (i % 2 == 0); req_set = 4'd6; req_hit = 8'h00;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("hold_way_end", 32'(resp_way), 32'd3);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", 32'(resp_valid), 32'd0);
    check("hold_ready_back", 32'(req_ready), 32'd1);
    do_req(4'd6, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "s6_miss");

    // 6a: reset while in UPDATE abandons the request and clears PLRU
    req_valid = 1'b1; req_set = 4'd0; req_hit = 8'h00; req_valid_ways = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_upd_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_upd_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_upd_resp_way", 32'(resp_way), 32'd0);
    @(posedge clk); #1;
    check("rst_upd_idle", 32'(resp_valid), 32'd0);
    do_req(4'd0, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "rst_s0");
    do_req(4'd2, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "rst_s2");

    // 6b: flush wins over a simultaneous request and clears PLRU
    flush = 1'b1;
    req_valid = 1'b1; req_set = 4'd0; req_hit = 8'h00; req_valid_ways = 8'hFF;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_not_taken", 32'(resp_valid), 32'd0);
    do_req(4'd0, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "flush_s0");
    do_req(4'd2, 8'h00, 8'hFF, 3'd0, 1'b0, 1'b0, "flush_s2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
